btn_conditioner: RTL and testbench

Input conditioner between the raw active-low push-buttons of the vending machine board and the vending FSM's active-high button strobes. Per channel it synchronises, debounces and edge-detects the button, producing one clean single-cycle pulse per press plus a debounced level. It replaces the single input register in front of the FSM, so the FSM sees exactly one `btn_coin`/`btn_buy`/`btn_cancel`/`btn_start` pulse per physical press. Optional auto-repeat lets a held button generate repeated pulses.

---
 rtl/btn_conditioner.sv | 146 ++++++++++++++
 tb/tb_btn_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop sync, debounce, armed press strobe.
// Optional auto-repeat on masked channels when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned       REPEAT_DELAY  = 25000000,
    parameter int unsigned       REPEAT_PERIOD = 10000000,
    parameter logic [N_BTN-1:0]  REPEAT_MASK   = N_BTN'(1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_armed
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]            sync1_q, sync1_d;
    logic [N_BTN-1:0]            sync2_q, sync2_d;
    logic [1:0]                  fill_q, fill_d;
    logic [N_BTN-1:0]            stable_q, stable_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0]            armed_q, armed_d;
    logic [N_BTN-1:0]            pulse_q, pulse_d;
    logic [N_BTN-1:0]            press_c;
    logic [N_BTN-1:0]            rpt_pulse_c;

    // Synchroniser, debounce counter, arming and press-edge detection.
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        fill_d   = {fill_q[0], 1'b1};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        press_c  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (~sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
            // Arm only once the synchroniser holds a real sample of a released button,
            // so a button held through reset cannot produce a press.
            if (fill_q[1] && !stable_q[i] && sync2_q[i]) begin
                armed_d[i] = 1'b1;
            end
            press_c[i] = armed_q[i] & ~stable_q[i] & stable_d[i];
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned      RPT_W           = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [N_BTN-1:0]            rpt_run_q, rpt_run_d;
    logic [N_BTN-1:0]            rpt_first_q, rpt_first_d;
    logic [N_BTN-1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // Repeat timer: started by a press strobe, stopped as soon as the level drops.
    always_comb begin
        rpt_run_d   = rpt_run_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_pulse_c = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (!REPEAT_MASK[i] || !stable_d[i]) begin
                rpt_run_d[i]   = 1'b0;
                rpt_first_d[i] = 1'b0;
                rpt_cnt_d[i]   = '0;
            end else if (press_c[i]) begin
                rpt_run_d[i]   = 1'b1;
                rpt_first_d[i] = 1'b1;
                rpt_cnt_d[i]   = '0;
            end else if (rpt_run_q[i]) begin
                if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                    rpt_pulse_c[i] = 1'b1;
                    rpt_first_d[i] = 1'b0;
                    rpt_cnt_d[i]   = '0;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_run_q   <= '0;
            rpt_first_q <= '0;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_run_q   <= rpt_run_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`else
    always_comb begin
        rpt_pulse_c = '0;
    end
`endif

    always_comb begin
        pulse_d = press_c | rpt_pulse_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            fill_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            armed_q  <= '0;
            pulse_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            fill_q   <= fill_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            pulse_q  <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_level = stable_q;
    assign btn_armed = armed_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table for level/arming, pulse scoreboard checked every cycle.
module tb_btn_conditioner;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_armed;

    typedef struct {
        int unsigned edge_n;
        logic [3:0]  mask;
    } pexp_t;

    typedef struct {
        logic [3:0]  btn;
        int unsigned hold;
        int unsigned poff;
        logic [3:0]  pmask;
        logic [3:0]  level;
        logic [3:0]  armed;
    } vec_t;

    pexp_t       sbq[$];
    vec_t        vt[9];
    int unsigned edge_n  = 0;
    int          passed  = 0;
    int          total   = 0;
    bit          mon_en  = 1'b0;
    logic [3:0]  mon_exp;

    btn_conditioner #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5),
        .REPEAT_MASK(4'b0001)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level),
        .btn_armed(btn_armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // d = edges after e0, where e0 is the next edge (first to sample the new btn value)
    task automatic expect_pulse(input int unsigned d, input logic [3:0] m);
        pexp_t p;
        p.edge_n = edge_n + 1 + d;
        p.mask   = m;
        sbq.push_back(p);
    endtask

    // Pulse scoreboard: every cycle the pulse vector must equal the queued mask or zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() != 0 && sbq[0].edge_n == edge_n) begin
                mon_exp = sbq[0].mask;
                void'(sbq.pop_front());
            end else begin
                mon_exp = 4'h0;
            end
            chk("pulse", 32'(btn_pulse), 32'(mon_exp));
        end
    end

    initial begin
        vt[0] = '{4'hF, 4,  0, 4'h0, 4'h0, 4'hF};  // idle after reset: arms all
        vt[1] = '{4'hD, 8,  5, 4'h2, 4'h2, 4'hF};  // clean press bit 1
        vt[2] = '{4'hF, 8,  0, 4'h0, 4'h0, 4'hF};  // release, no pulse
        vt[3] = '{4'hA, 8,  5, 4'h5, 4'h5, 4'hF};  // bits 0 and 2 together
        vt[4] = '{4'hF, 8,  0, 4'h0, 4'h0, 4'hF};
        vt[5] = '{4'h7, 3,  0, 4'h0, 4'h0, 4'hF};  // 3-cycle glitch rejected
        vt[6] = '{4'hF, 8,  0, 4'h0, 4'h0, 4'hF};
        vt[7] = '{4'h7, 4,  5, 4'h8, 4'h0, 4'hF};  // 4-cycle low is just accepted
        vt[8] = '{4'hF, 10, 0, 4'h0, 4'h0, 4'hF};

        rst = 1'b1;
        btn = 4'hF;
        tick(1);
        mon_en = 1'b1;
        tick(2);
        chk("reset_pulse", 32'(btn_pulse), 32'h0);
        chk("reset_level", 32'(btn_level), 32'h0);
        chk("reset_armed", 32'(btn_armed), 32'h0);

        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            btn = vt[i].btn;
            if (vt[i].pmask != 4'h0) expect_pulse(vt[i].poff, vt[i].pmask);
            tick(vt[i].hold);
            chk($sformatf("vec%0d_level", i), 32'(btn_level), 32'(vt[i].level));
            chk($sformatf("vec%0d_armed", i), 32'(btn_armed), 32'(vt[i].armed));
        end

        // bit 0 bounces low/high every 2 cycles, then settles low
        for (int k = 0; k < 5; k++) begin
            btn = 4'hE;
            tick(2);
            chk("bounce_level", 32'(btn_level), 32'h0);
            btn = 4'hF;
            tick(2);
        end
        btn = 4'hE;
        expect_pulse(5, 4'h1);
        tick(12);
        chk("bounce_held_level", 32'(btn_level), 32'h1);
        btn = 4'hF;
        tick(10);
        chk("bounce_release_level", 32'(btn_level), 32'h0);

        // bits 0 and 1 held: repeats only on bit 0 in the auto-repeat build
        btn = 4'hC;
        expect_pulse(5, 4'h3);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 1; k <= 6; k++) expect_pulse(10 + 5 * k, 4'h1);
`endif
        tick(38);
        chk("hold_level", 32'(btn_level), 32'h3);
        btn = 4'hF;
        tick(12);
        chk("hold_release_level", 32'(btn_level), 32'h0);

        // bit 3 held low through reset deassertion
        rst = 1'b1;
        btn = 4'h7;
        tick(3);
        chk("rst3_armed", 32'(btn_armed), 32'h0);
        rst = 1'b0;
        tick(12);
        chk("held_rst_armed", 32'(btn_armed), 32'h7);
        chk("held_rst_level", 32'(btn_level), 32'h8);
        btn = 4'hF;
        tick(10);
        chk("held_rel_armed", 32'(btn_armed), 32'hF);
        chk("held_rel_level", 32'(btn_level), 32'h0);
        btn = 4'h7;
        expect_pulse(5, 4'h8);
        tick(8);
        chk("repress3_level", 32'(btn_level), 32'h8);
        btn = 4'hF;
        tick(10);

        // reset while bit 1 is mid-debounce and bit 2 is held pressed
        btn = 4'hB;
        expect_pulse(5, 4'h4);
        tick(8);
        chk("pre_rst_level", 32'(btn_level), 32'h4);
        btn = 4'h9;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_pulse", 32'(btn_pulse), 32'h0);
        chk("mid_rst_level", 32'(btn_level), 32'h0);
        chk("mid_rst_armed", 32'(btn_armed), 32'h0);
        rst = 1'b0;
        tick(12);
        chk("post_rst_armed", 32'(btn_armed), 32'h9);
        chk("post_rst_level", 32'(btn_level), 32'h6);
        btn = 4'hF;
        tick(10);
        chk("post_rel_armed", 32'(btn_armed), 32'hF);
        btn = 4'hD;
        expect_pulse(5, 4'h2);
        tick(8);
        btn = 4'hF;
        tick(10);

        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
